vid_in_axi4s_formatter_ctrl: RTL and testbench

//  Sits in the native-video clock domain, directly ahead of the vid-in AXI4-Stream coupler FIFO.

---
 rtl/vid_in_axi4s_formatter_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_vid_in_axi4s_formatter_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/vid_in_axi4s_formatter_ctrl.sv
// vid_in_axi4s_formatter_ctrl
//   Native-video-domain front end of the vid-in AXI4-Stream coupler. It locks
//   onto the incoming timing, then writes active pixels into the coupler FIFO.
//   Each written word is tagged with SOF, EOL and field ID. The block drops
//   lock on FIFO overflow, and it reports the measured active size and the
//   number of overflow events.
// Ports
//   VID_IN_CLK, VID_RESET    clock, synchronous active-high reset
//   VID_CE                   clock enable qualifying all timing inputs
//   VID_DE/VBLANK/FIELD_ID   native timing; VID_DATA pixel data
//   AXIS_ENABLE              allows locking and writing
//   FIFO_OVERFLOW            overflow pulse from the coupler FIFO (any edge)
//   FIFO_WR_DATA/WR_EN       {FID,EOL,SOF,DATA} write request (coupler ANDs with CE)
//   LOCKED                   high while locked
//   ACTIVE_PIXELS/LINES      last measured active width / height
//   OVF_COUNT                saturating overflow count while locked
`timescale 1ns/1ps
module vid_in_axi4s_formatter_ctrl #(
  parameter int unsigned C_NATIVE_DATA_WIDTH = 24,
  parameter int unsigned C_CNT_WIDTH         = 13,
  parameter int unsigned C_OVF_CNT_WIDTH     = 8
) (
  input  logic                           VID_IN_CLK,
  input  logic                           VID_RESET,
  input  logic                           VID_CE,
  input  logic                           VID_DE,
  input  logic                           VID_VBLANK,
  input  logic                           VID_FIELD_ID,
  input  logic [C_NATIVE_DATA_WIDTH-1:0] VID_DATA,
  input  logic                           AXIS_ENABLE,
  input  logic                           FIFO_OVERFLOW,
  output logic [C_NATIVE_DATA_WIDTH+2:0] FIFO_WR_DATA,
  output logic                           FIFO_WR_EN,
  output logic                           LOCKED,
  output logic [C_CNT_WIDTH-1:0]         ACTIVE_PIXELS,
  output logic [C_CNT_WIDTH-1:0]         ACTIVE_LINES,
  output logic [C_OVF_CNT_WIDTH-1:0]     OVF_COUNT
);

  localparam int unsigned DW = C_NATIVE_DATA_WIDTH;
  localparam int unsigned CW = C_CNT_WIDTH;
  localparam int unsigned OW = C_OVF_CNT_WIDTH;

  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_WAIT_VBLANK = 2'd1;
  localparam logic [1:0] ST_WAIT_ACTIVE = 2'd2;
  localparam logic [1:0] ST_LOCKED      = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic          vblank_q;
  logic          de_q;
  logic          stage_valid;
  logic [DW-1:0] stage_data;
  logic          stage_sof;
  logic          stage_fid;
  logic          sof_pending;
  logic [CW-1:0] pix_cnt;
  logic [CW-1:0] line_cnt;

  logic          vblank_rise;
  logic          de_fall;
  logic          leave_locked;
  logic          lock_entry;
  logic          ovf_event;
  logic          measure;
  logic [CW-1:0] line_after_de;

  // Edge detection against the previous CE cycle
  assign vblank_rise  = VID_VBLANK & ~vblank_q;
  assign de_fall      = ~VID_DE & de_q;
  assign leave_locked = (state == ST_LOCKED) && (state_next != ST_LOCKED);
  assign lock_entry   = (state == ST_WAIT_ACTIVE) && (state_next == ST_LOCKED);
  assign ovf_event    = (state == ST_LOCKED) && FIFO_OVERFLOW;
  assign measure      = VID_CE && (state != ST_IDLE);

  // A line ending in the same cycle as VBLANK rising still counts toward that frame
  assign line_after_de = (de_fall && (line_cnt != '1)) ? line_cnt + CW'(1) : line_cnt;

  // State register
  always_ff @(posedge VID_IN_CLK) begin
    if (VID_RESET) state <= ST_IDLE;
    else           state <= state_next;
  end

  // Next-state logic; overflow acts at any edge, everything else only on CE
  always_comb begin
    state_next = state;
    if ((state == ST_LOCKED) && FIFO_OVERFLOW) begin
      state_next = AXIS_ENABLE ? ST_WAIT_VBLANK : ST_IDLE;
    end else if (VID_CE) begin
      case (state)
        ST_IDLE:        if (AXIS_ENABLE) state_next = ST_WAIT_VBLANK;
        ST_WAIT_VBLANK: if (!AXIS_ENABLE) state_next = ST_IDLE;
                        else if (VID_VBLANK) state_next = ST_WAIT_ACTIVE;
        ST_WAIT_ACTIVE: if (!AXIS_ENABLE) state_next = ST_IDLE;
                        else if (VID_DE && !VID_VBLANK) state_next = ST_LOCKED;
        ST_LOCKED:      if (!AXIS_ENABLE) state_next = ST_IDLE;
        default:        state_next = ST_IDLE;
      endcase
    end
  end

  // Pixel stage, write port, measurement and overflow counters
  always_ff @(posedge VID_IN_CLK) begin
    if (VID_RESET) begin
      vblank_q      <= 1'b0;
      de_q          <= 1'b0;
      stage_valid   <= 1'b0;
      stage_data    <= '0;
      stage_sof     <= 1'b0;
      stage_fid     <= 1'b0;
      sof_pending   <= 1'b0;
      pix_cnt       <= '0;
      line_cnt      <= '0;
      FIFO_WR_DATA  <= '0;
      FIFO_WR_EN    <= 1'b0;
      LOCKED        <= 1'b0;
      ACTIVE_PIXELS <= '0;
      ACTIVE_LINES  <= '0;
      OVF_COUNT     <= '0;
    end else begin
      LOCKED <= (state_next == ST_LOCKED);

      if (ovf_event && (OVF_COUNT != '1)) OVF_COUNT <= OVF_COUNT + OW'(1);

      if (VID_CE) begin
        vblank_q <= VID_VBLANK;
        de_q     <= VID_DE;
      end

      if (measure) begin
        if (VID_DE) begin
          if (pix_cnt != '1) pix_cnt <= pix_cnt + CW'(1);
        end else if (de_fall) begin
          ACTIVE_PIXELS <= pix_cnt;
          pix_cnt       <= '0;
        end
        if (vblank_rise) begin
          ACTIVE_LINES <= line_after_de;
          line_cnt     <= '0;
        end else begin
          line_cnt <= line_after_de;
        end
      end

      // Losing lock throws away the staged pixel and any pending write
      if (leave_locked) begin
        stage_valid <= 1'b0;
        sof_pending <= 1'b0;
        FIFO_WR_EN  <= 1'b0;
      end else if (VID_CE) begin
        FIFO_WR_EN <= 1'b0;
        if (lock_entry) begin
          stage_valid <= 1'b1;
          stage_data  <= VID_DATA;
          stage_sof   <= 1'b1;
          stage_fid   <= VID_FIELD_ID;
          sof_pending <= 1'b0;
        end else if (state == ST_LOCKED) begin
          if (VID_DE) begin
            // Another pixel follows, so the staged one is not the last of its line
            if (stage_valid) begin
              FIFO_WR_DATA <= {stage_fid, 1'b0, stage_sof, stage_data};
              FIFO_WR_EN   <= 1'b1;
            end
            stage_valid <= 1'b1;
            stage_data  <= VID_DATA;
            stage_sof   <= sof_pending | vblank_rise;
            stage_fid   <= VID_FIELD_ID;
            sof_pending <= 1'b0;
          end else begin
            if (vblank_rise) sof_pending <= 1'b1;
            if (stage_valid) begin
              FIFO_WR_DATA <= {stage_fid, 1'b1, stage_sof, stage_data};
              FIFO_WR_EN   <= 1'b1;
              stage_valid  <= 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vid_in_axi4s_formatter_ctrl.sv
// Testbench for vid_in_axi4s_formatter_ctrl. Frames are described as
// width/height/field; the expected FIFO words and the CE cycle at which each
// must be written are derived from the frame description and queued, and a
// compare process pops one entry per coupler write.
`timescale 1ns/1ps
module tb_vid_in_axi4s_formatter_ctrl;

  localparam int unsigned DW = 24;
  localparam int unsigned CW = 13;
  localparam int unsigned OW = 8;

  logic          clk = 1'b0;
  logic          VID_RESET = 1'b1;
  logic          VID_CE = 1'b1;
  logic          VID_DE = 1'b0;
  logic          VID_VBLANK = 1'b0;
  logic          VID_FIELD_ID = 1'b0;
  logic [DW-1:0] VID_DATA = '0;
  logic          AXIS_ENABLE = 1'b1;
  logic          FIFO_OVERFLOW = 1'b0;
  logic [DW+2:0] FIFO_WR_DATA;
  logic          FIFO_WR_EN;
  logic          LOCKED;
  logic [CW-1:0] ACTIVE_PIXELS;
  logic [CW-1:0] ACTIVE_LINES;
  logic [OW-1:0] OVF_COUNT;

  vid_in_axi4s_formatter_ctrl dut (
    .VID_IN_CLK   (clk),
    .VID_RESET    (VID_RESET),
    .VID_CE       (VID_CE),
    .VID_DE       (VID_DE),
    .VID_VBLANK   (VID_VBLANK),
    .VID_FIELD_ID (VID_FIELD_ID),
    .VID_DATA     (VID_DATA),
    .AXIS_ENABLE  (AXIS_ENABLE),
    .FIFO_OVERFLOW(FIFO_OVERFLOW),
    .FIFO_WR_DATA (FIFO_WR_DATA),
    .FIFO_WR_EN   (FIFO_WR_EN),
    .LOCKED       (LOCKED),
    .ACTIVE_PIXELS(ACTIVE_PIXELS),
    .ACTIVE_LINES (ACTIVE_LINES),
    .OVF_COUNT    (OVF_COUNT)
  );

  always #5 clk = ~clk;

  int unsigned   checks = 0;
  int unsigned   errors = 0;
  int unsigned   ce_cnt = 0;
  int unsigned   writes_seen = 0;
  int unsigned   ovf_exp = 0;
  logic [DW+2:0] last_word = '0;
  bit            ce_gap = 1'b0;
  logic [DW+2:0] exp_word_q[$];
  int unsigned   exp_ce_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Count of completed CE edges
  always @(posedge clk) if (VID_CE) ce_cnt <= ce_cnt + 1;

  // Each CE edge with WR_EN high is one coupler write; check it against the queue
  always @(negedge clk) begin
    if (VID_CE === 1'b1 && FIFO_WR_EN === 1'b1) begin
      writes_seen++;
      last_word = FIFO_WR_DATA;
      if (exp_word_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got word 0x%0h, required no write", FIFO_WR_DATA);
      end else begin
        logic [DW+2:0] w;
        int unsigned   c;
        w = exp_word_q.pop_front();
        c = exp_ce_q.pop_front();
        check("wr_word", 32'(FIFO_WR_DATA), 32'(w));
        check("wr_latency_ce", ce_cnt + 1, c);
      end
    end
  end

  // One CE cycle; with ce_gap set it is followed by two CE=0 cycles of junk inputs
  task automatic cyc(input logic de, input logic vb, input logic fid, input logic [DW-1:0] d,
                     input logic ovf, input logic en, input logic rst, output int unsigned samp);
    VID_DE = de; VID_VBLANK = vb; VID_FIELD_ID = fid; VID_DATA = d;
    FIFO_OVERFLOW = ovf; AXIS_ENABLE = en; VID_RESET = rst; VID_CE = 1'b1;
    samp = ce_cnt + 1;
    @(posedge clk); #1;
    FIFO_OVERFLOW = 1'b0; AXIS_ENABLE = 1'b1; VID_RESET = 1'b0;
    if (ce_gap) begin
      for (int i = 0; i < 2; i++) begin
        VID_CE = 1'b0; VID_DATA = ~d; VID_DE = ~de; VID_FIELD_ID = ~fid;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic blank(input logic vb);
    int unsigned s;
    cyc(1'b0, vb, 1'b0, '0, 1'b0, 1'b1, 1'b0, s);
  endtask

  // Lines of 2 hblank + w active cycles, then 2 hblank and 3 vblank cycles.
  // kill_kind: 0 overflow, 1 enable low, 2 reset, applied with pixel (kill_line, kill_pix).
  // A pixel is written only once its successor sample has happened before the kill.
  task automatic frame(input int w, input int h, input logic fid, input bit wr,
                       input int kill_line, input int kill_pix, input int kill_kind);
    int unsigned   s;
    logic [DW-1:0] d;
    bit            kn;
    for (int l = 0; l < h; l++) begin
      blank(1'b0);
      blank(1'b0);
      for (int p = 0; p < w; p++) begin
        d  = DW'(l * 16 + p);
        kn = (l == kill_line) && (p == kill_pix);
        cyc(1'b1, 1'b0, fid, d, kn && kill_kind == 0, !(kn && kill_kind == 1),
            kn && kill_kind == 2, s);
        if (wr && (kill_line < 0 || l < kill_line || (l == kill_line && p + 1 < kill_pix))) begin
          exp_word_q.push_back({fid, logic'(p == w - 1), logic'(l == 0 && p == 0), d});
          exp_ce_q.push_back(s + 2);
        end
        if (kn) begin
          check("kill_locked", 32'(LOCKED), 32'd0);
          check("kill_wr_en", 32'(FIFO_WR_EN), 32'd0);
          if (kill_kind == 0) begin
            if (ovf_exp < 255) ovf_exp++;
            check("kill_ovf_count", 32'(OVF_COUNT), ovf_exp);
          end
          if (kill_kind == 2) begin
            ovf_exp = 0;
            check("rst_wr_data", 32'(FIFO_WR_DATA), 32'd0);
            check("rst_pixels", 32'(ACTIVE_PIXELS), 32'd0);
            check("rst_lines", 32'(ACTIVE_LINES), 32'd0);
            check("rst_ovf", 32'(OVF_COUNT), 32'd0);
          end
        end
      end
    end
    blank(1'b0);
    blank(1'b0);
    for (int i = 0; i < 3; i++) blank(1'b1);
  endtask

  initial begin
    int unsigned s;
    int unsigned w0;

    // Reset
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, s);
    check("rst_wr_en", 32'(FIFO_WR_EN), 32'd0);
    check("rst_wr_data", 32'(FIFO_WR_DATA), 32'd0);
    check("rst_locked", 32'(LOCKED), 32'd0);
    check("rst_pixels", 32'(ACTIVE_PIXELS), 32'd0);
    check("rst_lines", 32'(ACTIVE_LINES), 32'd0);
    check("rst_ovf", 32'(OVF_COUNT), 32'd0);

    // 4x3 frames: nothing before the first VBLANK, then a full frame
    frame(4, 3, 1'b0, 1'b0, -1, 0, 0);
    check("t1_no_writes_before_vblank", writes_seen, 0);
    check("t1_locked_after_vblank", 32'(LOCKED), 32'd0);
    frame(4, 3, 1'b0, 1'b1, -1, 0, 0);
    check("t1_writes", writes_seen, 12);
    check("t1_last_word", 32'(last_word), 32'h0200_0023);
    check("t1_pixels", 32'(ACTIVE_PIXELS), 32'd4);
    check("t1_lines", 32'(ACTIVE_LINES), 32'd3);
    check("t1_locked", 32'(LOCKED), 32'd1);

    // CE pattern 1,0,0
    ce_gap = 1'b1;
    w0 = writes_seen;
    frame(4, 3, 1'b0, 1'b1, -1, 0, 0);
    ce_gap = 1'b0;
    check("t2_writes", writes_seen - w0, 12);
    check("t2_pixels", 32'(ACTIVE_PIXELS), 32'd4);
    check("t2_lines", 32'(ACTIVE_LINES), 32'd3);

    // Overflow mid-line 1, then relock on the next frame
    w0 = writes_seen;
    frame(4, 3, 1'b0, 1'b1, 1, 2, 0);
    check("t3_writes", writes_seen - w0, 5);
    check("t3_ovf_count", 32'(OVF_COUNT), 32'd1);
    frame(4, 3, 1'b0, 1'b1, -1, 0, 0);
    check("t3_relocked", 32'(LOCKED), 32'd1);

    // Enable low mid-line, then relock only after VBLANK
    w0 = writes_seen;
    frame(4, 3, 1'b0, 1'b1, 1, 2, 1);
    check("t4_writes", writes_seen - w0, 5);
    check("t4_ovf_unchanged", 32'(OVF_COUNT), 32'd1);
    frame(4, 3, 1'b0, 1'b1, -1, 0, 0);

    // Single-pixel lines
    w0 = writes_seen;
    frame(1, 3, 1'b0, 1'b1, -1, 0, 0);
    frame(1, 3, 1'b0, 1'b1, -1, 0, 0);
    check("t5_writes", writes_seen - w0, 6);
    check("t5_last_word", 32'(last_word), 32'h0200_0020);
    check("t5_pixels", 32'(ACTIVE_PIXELS), 32'd1);

    // Alternating field ID
    frame(4, 3, 1'b1, 1'b1, -1, 0, 0);
    frame(4, 3, 1'b0, 1'b1, -1, 0, 0);
    frame(4, 3, 1'b1, 1'b1, -1, 0, 0);
    check("t6_last_word_fid1", 32'(last_word), 32'h0600_0023);

    // 300 overflows, each from a freshly locked state
    for (int i = 0; i < 300; i++) begin
      cyc(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, s);
      cyc(1'b1, 1'b0, 1'b0, 24'h0000AA, 1'b0, 1'b1, 1'b0, s);
      cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, s);
      if (ovf_exp < 255) ovf_exp++;
      if (i == 99) check("t6_ovf_after_100", 32'(OVF_COUNT), 32'd101);
    end
    check("t6_ovf_model", 32'(OVF_COUNT), ovf_exp);
    check("t6_ovf_saturated", 32'(OVF_COUNT), 32'd255);
    check("t6_unlocked", 32'(LOCKED), 32'd0);

    // Reset mid-frame while locked
    frame(4, 3, 1'b0, 1'b0, -1, 0, 0);
    w0 = writes_seen;
    frame(4, 3, 1'b0, 1'b1, 1, 1, 2);
    check("t7_writes", writes_seen - w0, 4);
    check("t7_locked", 32'(LOCKED), 32'd0);

    check("queue_empty", 32'(exp_word_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
